// File: rtl/dm_bist_pkg.sv
// Shared definitions for the data-memory BIST top.
// Contents: the FSM state encoding, the pattern-select codes and pat(), the
// pattern generator that both the write path and the compare path use.
package dm_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_NADDR = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_WALK1 = 2'd3;

    // The result is always 32 bits wide. Callers keep the low data_w bits.
    // data_w sets the period of the walking-one pattern.
    function automatic logic [31:0] pat(input logic [31:0] a, input logic [1:0] s,
                                        input int unsigned data_w);
        logic [31:0] r;
        r = '0;
        case (s)
            PAT_ADDR:  r = a;
            PAT_NADDR: r = ~a;
            PAT_CHECK: r = a[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            default:   r = 32'd1 << (a % data_w);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Synchronous single-port data RAM. Reads are read-first with a 1-cycle latency.
// Ports: clk; i_we write enable; i_addr word address; i_wdata write data;
//        o_rdata read data, registered.
// The array is not reset.
module dm_ram
    import dm_bist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_addr];
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_bist_top.sv
// Board-level data-memory test top. It provides manual switch-driven writes and
// reads, and an automatic fill / read-back / compare self-test.
// Ports: clk, rst_n (async, active-low); mode (0 manual, 1 auto); start and
//        mem_write (asynchronous switches, edge-detected); addr, pat_sel;
//        disp_data (registered read data); busy, done, pass, err_count
//        (saturating), fail_addr (first mismatch).
// Optional build macro FAULT_INJECT_EN adds the fault_inj input. While
// fault_inj is 1, auto-mode writes to address 3 have bit 0 inverted.
module dm_bist_top
    import dm_bist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        pat_sel,
`ifdef FAULT_INJECT_EN
    input  logic              fault_inj,
`endif
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_e            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [1:0]        r_pat_q;
    logic [ERR_W-1:0]  r_err;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_disp;
    logic [1:0]        r_start_sync;
    logic              r_start_q;
    logic [1:0]        r_wr_sync;
    logic              r_wr_q;
    logic              r_vld_p1;
    logic [DATA_W-1:0] r_exp_p1;
    logic [ADDR_W-1:0] r_addr_p1;

    logic              w_start_p;
    logic              w_wr_p;
    logic              w_idle_like;
    logic              w_launch;
    logic              w_man_wr;
    logic              w_fault_flip;
    logic              w_mis;
    logic [31:0]       w_pat_cnt_full;
    logic [31:0]       w_pat_man_full;
    logic [DATA_W-1:0] w_pat_cnt;
    logic [DATA_W-1:0] w_pat_man;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_start_p   = r_start_sync[1] & ~r_start_q;
    assign w_wr_p      = r_wr_sync[1] & ~r_wr_q;
    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign w_launch    = w_idle_like && mode && w_start_p;
    assign w_man_wr    = w_idle_like && !mode && w_wr_p;

    assign w_pat_cnt_full = pat(32'(r_cnt), r_pat_q, DATA_W);
    assign w_pat_man_full = pat(32'(addr), pat_sel, DATA_W);
    assign w_pat_cnt      = w_pat_cnt_full[DATA_W-1:0];
    assign w_pat_man      = w_pat_man_full[DATA_W-1:0];

`ifdef FAULT_INJECT_EN
    assign w_fault_flip = fault_inj && (r_cnt == ADDR_W'(3));
`else
    assign w_fault_flip = 1'b0;
`endif

    // The single RAM port serves the auto sequence while it runs. Otherwise
    // it serves the switches, so the RAM is read at addr on every idle cycle.
    assign w_ram_we    = (r_state == WRITE) || w_man_wr;
    assign w_ram_addr  = ((r_state == WRITE) || (r_state == READ)) ? r_cnt : addr;
    assign w_ram_wdata = (r_state == WRITE) ? (w_pat_cnt ^ DATA_W'(w_fault_flip)) : w_pat_man;

    dm_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_mis = (w_ram_rdata != r_exp_p1);

    // Stage p0 -> p1: the read is issued at r_cnt. The expected word and the
    // address travel one cycle alongside it to meet the RAM output.
    always_ff @(posedge clk) begin
        r_exp_p1  <= w_pat_cnt;
        r_addr_p1 <= r_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_pat_q      <= '0;
            r_err        <= '0;
            r_fail_addr  <= '0;
            r_disp       <= '0;
            r_start_sync <= '0;
            r_start_q    <= 1'b0;
            r_wr_sync    <= '0;
            r_wr_q       <= 1'b0;
            r_vld_p1     <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[0], start};
            r_start_q    <= r_start_sync[1];
            r_wr_sync    <= {r_wr_sync[0], mem_write};
            r_wr_q       <= r_wr_sync[1];
            r_vld_p1     <= (r_state == READ);
            r_disp       <= w_ram_rdata;

            // Stage p1: compare. A zero count means this is the first
            // mismatch, and that still holds after the count saturates.
            if (r_vld_p1 && w_mis) begin
                if (r_err != '1) begin
                    r_err <= r_err + ERR_W'(1);
                end
                if (r_err == '0) begin
                    r_fail_addr <= r_addr_p1;
                end
            end

            unique case (r_state)
                IDLE, DONE: begin
                    if (w_launch) begin
                        r_state     <= WRITE;
                        r_cnt       <= '0;
                        r_pat_q     <= pat_sel;
                        r_err       <= '0;
                        r_fail_addr <= '0;
                    end
                end
                WRITE: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == LAST) begin
                        r_state <= READ;
                        r_cnt   <= '0;
                    end
                end
                READ: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == LAST) begin
                        r_state <= DRAIN;
                        r_cnt   <= '0;
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign disp_data = r_disp;
    assign busy      = (r_state == WRITE) || (r_state == READ) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign pass      = (r_state == DONE) && (r_err == '0);
    assign err_count = r_err;
    assign fail_addr = r_fail_addr;

endmodule

// File: tb/tb_dm_bist_top.sv
// Randomised scoreboard bench for dm_bist_top. A second instance with a
// 2-bit error counter covers saturation.
module tb_dm_bist_top;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, mode, start, mem_write;
    logic [AW-1:0] addr;
    logic [1:0]    pat_sel;
    logic [DW-1:0] disp_data;
    logic          busy, done, pass;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;
`ifdef FAULT_INJECT_EN
    logic          fault_inj;
`endif

    logic          mode2, start2;
    logic [1:0]    pat_sel2;
    logic [DW-1:0] disp_data2;
    logic          busy2, done2, pass2;
    logic [1:0]    err_count2;
    logic [AW-1:0] fail_addr2;

    dm_bist_top #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .start     (start),
        .mem_write (mem_write),
        .addr      (addr),
        .pat_sel   (pat_sel),
`ifdef FAULT_INJECT_EN
        .fault_inj (fault_inj),
`endif
        .disp_data (disp_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    dm_bist_top #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode2),
        .start     (start2),
        .mem_write (1'b0),
        .addr      ({AW{1'b0}}),
        .pat_sel   (pat_sel2),
`ifdef FAULT_INJECT_EN
        .fault_inj (1'b0),
`endif
        .disp_data (disp_data2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_count (err_count2),
        .fail_addr (fail_addr2)
    );

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [DEPTH];
    string       names [0:10] = '{"disp_data", "busy", "done", "pass", "err_count",
                                  "fail_addr", "done2", "pass2", "err_count2",
                                  "fail_addr2", "busy2"};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_pat(input int a, input int s);
        case (s)
            0:       return 32'(a);
            1:       return ~(32'(a));
            2:       return (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
            default: return 32'h1 << (a % 32);
        endcase
    endfunction

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            0:       return disp_data;
            1:       return 32'(busy);
            2:       return 32'(done);
            3:       return 32'(pass);
            4:       return 32'(err_count);
            5:       return 32'(fail_addr);
            6:       return 32'(done2);
            7:       return 32'(pass2);
            8:       return 32'(err_count2);
            9:       return 32'(fail_addr2);
            default: return 32'(busy2);
        endcase
    endfunction

    // Scoreboard monitor: pops every expectation due this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] v;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            v = sig_val(e.sig);
            n_chk++;
            if (e.due != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed (now %0d), expected %h",
                         names[e.sig], e.due, cyc, e.val);
            end else if (v !== e.val) begin
                n_fail++;
                $display("FAIL %s @cycle %0d: got %h expected %h", names[e.sig], cyc, v, e.val);
            end
        end
    end

    task automatic push(input int due, input int sig, input logic [31:0] val);
        exp_t e;
        int   i;
        e.due = due;
        e.sig = sig;
        e.val = val;
        i = q.size();
        while (i > 0 && q[i-1].due > due) i--;
        q.insert(i, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            tick(1);
            n++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic man_write(input int a, input int s);
        int k;
        addr      = AW'(a);
        pat_sel   = 2'(s);
        mem_write = 1'b1;
        k = cyc;
        model_mem[a] = ref_pat(a, s);
        push(k + 5, 0, model_mem[a]);
        tick(3);
        mem_write = 1'b0;
        tick(3);
        wait_drain();
    endtask

    task automatic man_read(input int a);
        addr = AW'(a);
        push(cyc + 2, 0, model_mem[a]);
        tick(3);
        wait_drain();
    endtask

    task automatic auto_run(input int s, input int exp_pass, input int exp_err,
                            input int exp_fail, input bit poke);
        int k;
        int b;
        mode    = 1'b1;
        pat_sel = 2'(s);
        start   = 1'b1;
        k = cyc;
        b = k + 3;
        push(b - 1, 1, 0);
        push(b, 1, 1);
        push(b + 128, 2, 0);
        push(b + 129, 2, 1);
        push(b + 129, 1, 0);
        push(b + 129, 3, 32'(exp_pass));
        push(b + 129, 4, 32'(exp_err));
        push(b + 129, 5, 32'(exp_fail));
        tick(3);
        start = 1'b0;
        if (poke) begin
            while (cyc < b + 20) tick(1);
            start     = 1'b1;
            mem_write = 1'b1;
            mode      = 1'b0;
            addr      = AW'($urandom_range(0, DEPTH - 1));
            pat_sel   = 2'(s + 1);
            tick(3);
            start     = 1'b0;
            mem_write = 1'b0;
        end
        wait_drain();
        for (int a = 0; a < DEPTH; a++) model_mem[a] = ref_pat(a, s);
        mode = 1'b0;
        tick(2);
        push(cyc, 2, 1);
        push(cyc, 4, 32'(exp_err));
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int b;
        rst_n = 1'b0; mode = 1'b0; start = 1'b0; mem_write = 1'b0;
        addr = '0; pat_sel = '0;
        mode2 = 1'b0; start2 = 1'b0; pat_sel2 = '0;
`ifdef FAULT_INJECT_EN
        fault_inj = 1'b0;
`endif
        tick(2);
        for (int s = 0; s < 10; s++) push(cyc, s, 0);
        wait_drain();
        rst_n = 1'b1;
        tick(2);

        // Manual writes and read-back
        man_write(5, 2);
        man_write(4, 3);
        man_read(5);

        // Auto pass with inverted address, then manual read of address 7
        auto_run(1, 1, 0, 0, 1'b0);
        man_read(7);

        // start / mem_write / mode / pat_sel disturbed mid-run
        auto_run(2, 1, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) man_read($urandom_range(0, DEPTH - 1));

        // Reset in the middle of WRITE at cnt = 10
        mode = 1'b1; pat_sel = 2'd2; start = 1'b1;
        k = cyc;
        b = k + 3;
        push(b, 1, 1);
        tick(3);
        start = 1'b0;
        while (cyc < b + 10) tick(1);
        rst_n = 1'b0;
        for (int s = 0; s < 6; s++) push(cyc, s, 0);
        wait_drain();
        tick(1);
        rst_n = 1'b1;
        tick(2);
        auto_run(3, 1, 0, 0, 1'b0);
        man_read(9);

        // Randomised mix of manual and auto operations
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    man_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 3));
                2:       man_read($urandom_range(0, DEPTH - 1));
                default: begin
                    auto_run($urandom_range(0, 3), 1, 0, 0, 1'($urandom_range(0, 1)));
                    man_read($urandom_range(0, DEPTH - 1));
                end
            endcase
        end

`ifdef FAULT_INJECT_EN
        fault_inj = 1'b1;
        auto_run(0, 0, 1, 3, 1'b0);
        model_mem[3] = model_mem[3] ^ 32'h1;
        fault_inj = 1'b0;
        man_read(3);
`endif

        // Saturation on the 2-bit error counter: every read word is corrupted
        mode2 = 1'b1; pat_sel2 = 2'd0; start2 = 1'b1;
        k = cyc;
        b = k + 3;
        push(b, 10, 1);
        push(b + 129, 6, 1);
        push(b + 129, 7, 0);
        push(b + 129, 8, 3);
        push(b + 129, 9, 0);
        tick(3);
        start2 = 1'b0;
        force dut2.w_ram_rdata = 32'hFFFF_FFFF;
        wait_drain();
        release dut2.w_ram_rdata;

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
